bin_to_bcd_display: RTL and testbench



---
 rtl/bin_to_bcd_display.sv | 176 +++++++++++++++++
 tb/tb_bin_to_bcd_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_display
// Purpose  : Sequential 32-bit binary to 8-digit packed BCD converter using
//            iterative double-dabble, one bit per clock. Feeds the `data`
//            input of the 8-digit seven-segment scanner; nibble 4'hF renders
//            as a dash there, so out-of-range results are shown as all dashes.
// Ports    : clk      - system clock
//            rst      - asynchronous, active-low reset
//            wr_en    - start request, sampled only while idle
//            wr_data  - 32-bit binary value to convert
//            busy     - conversion in progress
//            done     - one-cycle pulse when data_out/ovf update
//            data_out - packed BCD, digit 7 in [31:28] ... digit 0 in [3:0]
//            ovf      - last conversion was out of range
// Config   : BIN_TO_BCD_SIGNED_EN - when defined, wr_data is two's complement
//            and negative results show a leading minus (4'hF) digit.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_display (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_out,
   output logic        ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [31:0] C_ALL_DASHES = 32'hFFFF_FFFF;
   localparam logic [4:0]  C_LAST_STEP  = 5'd31;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_bin;
   logic [39:0] r_acc;
   logic [4:0]  r_cnt;
   logic [31:0] r_data_out;
   logic        r_ovf;
   logic        r_done;

   logic [39:0] w_adj;
   logic [71:0] w_shifted;
   logic [31:0] w_capture;
   logic [31:0] w_result;
   logic        w_ovf;

`ifdef BIN_TO_BCD_SIGNED_EN
   logic        r_neg;
`endif

   // ------------------------------------------------------------------------
   // State register and next-state logic
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (wr_en) w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == C_LAST_STEP) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Double-dabble step: every digit >= 5 gets +3 before the shift, so that
   // the shift carries into the next decimal digit exactly when it reaches 10.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_digit
         assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                   (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
      end
   endgenerate

   // The bin MSB falls into the accumulator LSB; the adjusted digit 9 MSB
   // can never be set for a 32-bit input, so discarding it is safe.
   assign w_shifted = {w_adj, r_bin} << 1;

   // ------------------------------------------------------------------------
   // Capture and result formatting
   // ------------------------------------------------------------------------
   always_comb begin
      w_capture = wr_data;
      w_result  = r_acc[31:0];
      w_ovf     = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
      // Negative values are converted as their magnitude; -2^31 stays
      // 32'h8000_0000 which is correct as an unsigned magnitude.
      if (wr_data[31]) begin
         w_capture = ~wr_data + 32'd1;
      end
      if (r_neg) begin
         // Only seven digits are left once the minus sign takes digit 7.
         if (r_acc[39:28] != 12'd0) begin
            w_result = C_ALL_DASHES;
            w_ovf    = 1'b1;
         end else begin
            w_result = {4'hF, r_acc[27:0]};
         end
      end else if (r_acc[39:32] != 8'd0) begin
         w_result = C_ALL_DASHES;
         w_ovf    = 1'b1;
      end
`else
      if (r_acc[39:32] != 8'd0) begin
         w_result = C_ALL_DASHES;
         w_ovf    = 1'b1;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bin      <= 32'd0;
         r_acc      <= 40'd0;
         r_cnt      <= 5'd0;
         r_data_out <= C_ALL_DASHES;
         r_ovf      <= 1'b0;
         r_done     <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
         r_neg      <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wr_en) begin
                  r_bin <= w_capture;
                  r_acc <= 40'd0;
                  r_cnt <= 5'd0;
`ifdef BIN_TO_BCD_SIGNED_EN
                  r_neg <= wr_data[31];
`endif
               end
            end
            S_SHIFT: begin
               {r_acc, r_bin} <= w_shifted;
               r_cnt          <= r_cnt + 5'd1;
            end
            S_DONE: begin
               r_data_out <= w_result;
               r_ovf      <= w_ovf;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign data_out = r_data_out;
   assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_display
// Purpose  : Self-checking bench for bin_to_bcd_display: directed vector
//            table, busy-write and mid-conversion reset sequences, and random
//            values checked against a decimal-arithmetic reference model.
// Config   : honours BIN_TO_BCD_SIGNED_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_display;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [31:0] data_out;
   logic        ovf;

   int n_cmp;
   int n_err;

   bin_to_bcd_display dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .data_out (data_out),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [31:0] exp_data;
      logic        exp_ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain decimal arithmetic on the (signed or unsigned) value.
   function automatic void model(input logic [31:0] v, output logic [31:0] d, output logic o);
      longint unsigned mag;
      bit neg;
      neg = 1'b0;
      mag = 64'(v);
`ifdef BIN_TO_BCD_SIGNED_EN
      if (v[31]) begin
         neg = 1'b1;
         mag = 64'h1_0000_0000 - 64'(v);
      end
`endif
      if ((!neg && mag > 64'd99_999_999) || (neg && mag > 64'd9_999_999)) begin
         d = 32'hFFFF_FFFF;
         o = 1'b1;
      end else begin
         d = 32'd0;
         for (int i = 0; i < 8; i++) begin
            d[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
         end
         if (neg) d[31:28] = 4'hF;
         o = 1'b0;
      end
   endfunction

   // Start one conversion and wait (bounded) for its done pulse.
   task automatic convert(input logic [31:0] v, output logic [31:0] d,
                          output logic o, output int lat);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = v;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      wr_data = $urandom;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) break;
      end
      d = data_out;
      o = ovf;
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   vec_t        vecs[$];
   logic [31:0] d, ed, dcap, v;
   logic        o, eo;
   int          lat, ndone, first_lat;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_data = 32'd0;

      vecs.push_back('{32'd12_345_678, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'd0,          32'h0000_0000, 1'b0});
      vecs.push_back('{32'd99_999_999, 32'h9999_9999, 1'b0});
      vecs.push_back('{32'd100_000_000, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{32'd9,          32'h0000_0009, 1'b0});
`ifdef BIN_TO_BCD_SIGNED_EN
      vecs.push_back('{-32'sd1234,       32'hF000_1234, 1'b0});
      vecs.push_back('{-32'sd9_999_999,  32'hF999_9999, 1'b0});
      vecs.push_back('{-32'sd10_000_000, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{32'h8000_0000,    32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{32'hFFFF_FFFF,    32'hF000_0001, 1'b0});
`else
      vecs.push_back('{32'hFFFF_FFFF,    32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{32'h8000_0000,    32'hFFFF_FFFF, 1'b1});
`endif

      // Reset state, both during and after reset.
      repeat (3) @(negedge clk);
      chk("rst_data_out", data_out, 32'hFFFF_FFFF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_data_out", data_out, 32'hFFFF_FFFF);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_ovf", {31'd0, ovf}, 32'd0);

      // Directed table.
      foreach (vecs[i]) begin
         convert(vecs[i].din, d, o, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
         chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         chk($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].exp_ovf});
      end

      // Writes while busy are dropped; the first idle edge accepts a write.
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 32'd42;
      @(posedge clk);                       // edge N
      ndone = 0;
      dcap  = 32'd0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         wr_en   = (k == 5 || k == 33);
         wr_data = 32'd7;
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            dcap = data_out;
         end
      end
      chk("busy_write_done_count", 32'(ndone), 32'd1);
      chk("busy_write_data", dcap, 32'h0000_0042);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 32'd7;
      @(posedge clk);                       // edge N+34
      #1;
      wr_en     = 1'b0;
      chk("accept_at_n34_busy", {31'd0, busy}, 32'd1);
      ndone     = 0;
      first_lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            if (first_lat == 0) first_lat = k;
            dcap = data_out;
         end
      end
      chk("n34_done_count", 32'(ndone), 32'd1);
      chk("n34_latency", 32'(first_lat), 32'd33);
      chk("n34_data", dcap, 32'h0000_0007);

      // Reset in the middle of a conversion.
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 32'd555;
      @(posedge clk);                       // edge N
      #1;
      wr_en = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_data_out", data_out, 32'hFFFF_FFFF);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_ovf", {31'd0, ovf}, 32'd0);
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);
      chk("midrst_hold_data", data_out, 32'hFFFF_FFFF);
      convert(32'd9, d, o, lat);
      chk("after_rst_data", d, 32'h0000_0009);
      chk("after_rst_latency", 32'(lat), 32'd33);

      // Random values against the reference model.
      for (int i = 0; i < 40; i++) begin
         case ($urandom % 4)
            0: v = $urandom;
            1: v = $urandom % 100_000_000;
            2: v = -($urandom % 12_000_000);
            default: v = 32'd99_999_990 + ($urandom % 20);
         endcase
         model(v, ed, eo);
         convert(v, d, o, lat);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd33);
         chk($sformatf("rnd%0d_data(%h)", i, v), d, ed);
         chk($sformatf("rnd%0d_ovf(%h)", i, v), {31'd0, o}, {31'd0, eo});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
